// File: rtl/register_serializer_pkg.sv
// Shared types and constants for the register_serializer parallel-in/serial-out block.
package register_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Registered serial-side outputs, grouped so they reset and idle together.
    typedef struct packed {
        logic serial_out;
        logic frame;
        logic first_bit;
        logic done;
    } ser_out_t;

    localparam ser_out_t SER_OUT_IDLE = '{serial_out: 1'b0, frame: 1'b0, first_bit: 1'b0, done: 1'b0};

endpackage

// File: rtl/serializer_bit_counter.sv
// Remaining-bit counter for the serializer: loadable, decrements toward zero and never wraps.
module serializer_bit_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/register_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, gapless back-to-back words.
// Define REGISTER_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module register_serializer
    import register_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             frame,
    output logic             first_bit,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef REGISTER_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    ser_out_t         out_q, out_d;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;
    logic             cnt_load, cnt_dec;
    logic             accept;
`ifdef REGISTER_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    serializer_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
        .input_clock1_1 (input_clock1_1),
        .input_reset1_2 (input_reset1_2),
        .load           (cnt_load),
        .load_value     (CNT_W'(WIDTH - 1)),
        .dec            (cnt_dec),
        .count          (count),
        .zero_c         (cnt_zero)
    );

    // With parity the LSB cycle is always followed by the parity cycle, so ready moves there.
`ifdef REGISTER_SERIALIZER_PARITY_EN
    assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero);
`endif

    assign accept = load_valid && load_ready;

    // Next state and next registered outputs; outputs idle unless a bit is being sent.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        out_d    = SER_OUT_IDLE;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef REGISTER_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        if (accept) begin
            state_d          = SHIFT;
            shift_d          = load_data;
            cnt_load         = 1'b1;
            out_d.serial_out = load_data[WIDTH-1];
            out_d.frame      = 1'b1;
            out_d.first_bit  = 1'b1;
`ifdef REGISTER_SERIALIZER_PARITY_EN
            parity_d         = ^load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!cnt_zero) begin
                        shift_d          = shift_q << 1;
                        cnt_dec          = 1'b1;
                        out_d.serial_out = shift_q[WIDTH-2];
                        out_d.frame      = 1'b1;
                        out_d.done       = PARITY_EN ? 1'b0 : (count == CNT_W'(1));
                    end else begin
`ifdef REGISTER_SERIALIZER_PARITY_EN
                        state_d          = PARITY;
                        out_d.serial_out = parity_q;
                        out_d.frame      = 1'b1;
                        out_d.done       = 1'b1;
`else
                        state_d          = IDLE;
`endif
                    end
                end
                PARITY:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            out_q    <= SER_OUT_IDLE;
`ifdef REGISTER_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
`ifdef REGISTER_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out = out_q.serial_out;
    assign frame      = out_q.frame;
    assign first_bit  = out_q.first_bit;
    assign done       = out_q.done;

endmodule
